agc1: RTL and testbench
=======================

AGC1 -- requirements
Module: agc1

Interface
REQ-001 Parameter ATTACK_SH, default 3, shift that sets the attack step: gain reduced by gain>>ATTACK_SH.
REQ-002 Parameter DECAY_SH, default 8, shift that sets the decay step: gain raised by (gain>>DECAY_SH)+1.
REQ-003 Parameter GAIN_INIT, default 16'h1000, reset gain (unity in unsigned Q4.12).
REQ-004 clk  in  1  sample clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 dix, diy  in  18  signed I/Q samples; this block consumes the blanked pair from the noise blanker output.
REQ-007 iv  in  1  input pair valid; may be high on every cycle.
REQ-008 dox, doy  out  18  signed gain-scaled, saturated I/Q.
REQ-009 ov  out  1  output pair valid; one-cycle pulse per accepted input.
REQ-010 target  in  12  magnitude set point, unsigned, compared with mag[17:6].
REQ-011 hang  in  12  number of output samples to hold gain after an attack.
REQ-012 gmax  in  16  maximum gain, Q4.12.
REQ-013 freeze  in  1  hold gain, state and hang counter.
REQ-014 gain  out  16  current gain register, Q4.12.

Function
REQ-015 Pipeline: S1 captures dix/diy on iv; S2 registers the 18x16 signed-by-unsigned product (34 bits) using the gain value present on that edge; S3 registers the saturated output; ov is asserted with S3; latency from iv to ov is 3 cycles.
REQ-016 Scaling: out = product>>>12 (arithmetic); when the result is above 131071 it SHALL be clamped to 131071, and when it is below -131072 it SHALL be clamped to -131072.
REQ-017 Magnitude: a=|dox|, b=|doy| (|-131072| saturates to 131071); mag = max(a,b) + (min(a,b)>>1), 18-bit unsigned, saturating at 262143; mag and mv are registered one cycle after ov.
REQ-018 Gain update occurs only on an edge where mv=1 and freeze=0; gain is otherwise unchanged.
REQ-019 FSM states: DECAY (reset state) and HANG; a 12-bit hang counter hcnt.
REQ-020 Attack, any state, when mag[17:6] > target: gain <= max(gain - (gain>>ATTACK_SH), 1); hcnt <= hang; state <= HANG.
REQ-021 HANG with no attack: if hcnt==0 then state <= DECAY, else hcnt <= hcnt-1; gain is unchanged.
REQ-022 DECAY with no attack: gain <= min(gain + (gain>>DECAY_SH) + 1, gmax), computed 17 bits wide so there is no wrap; if gain>gmax already (gmax lowered at runtime), gain <= gmax.
REQ-023 mag[17:6]==target is not an attack.
REQ-024 hang=0: after an attack, the next non-attack sample returns the FSM to DECAY with no gain change.
REQ-025 freeze=1 coincident with an over-target sample: freeze wins; gain, hcnt and state are unchanged.
REQ-026 Gain changes never alter samples already in S2/S3; the gain change applies from the next S2 capture.
REQ-027 Back-to-back iv SHALL be sustained at one pair per clock, and no sample is dropped.

Reset
REQ-028 On rst_n low, asynchronously: dox=doy=0, ov=0, all pipeline valids=0, mv=0, gain=GAIN_INIT, state=DECAY, hcnt=0.
REQ-029 Reset mid-stream discards in-flight samples; no ov is produced for samples accepted before reset.
REQ-030 First accepted iv after rst_n rises yields ov exactly 3 cycles later.

Structure
REQ-031 Package agc_pkg holds GAIN_W=16, GAIN_FRAC=12, GAIN_UNITY=16'h1000, the 18-bit sample min/max constants and the FSM state enumeration.
REQ-032 One sub-module, cmag18 (registered alpha-max-beta-min magnitude of an 18-bit pair, 1-cycle latency), implements REQ-017; everything else is in agc1.

Verification
REQ-033 Unity pass-through: gain=0x1000, target=0xFFF, dix=1000, diy=-2000 single iv -> ov 3 cycles later, dox=1000, doy=-2000, gain unchanged.
REQ-034 Saturation: gmax=0x8000, force gain to 0x8000 via decay, dix=20000 -> dox=131071; dix=-20000 -> dox=-131072.
REQ-035 Attack/hang: target=0x100, hang=4, gain=0x1000, one sample with mag[17:6]=0x200 -> gain=0x0E00, state HANG; next 4 quiet samples leave gain 0x0E00; the 5th -> DECAY; the 6th -> gain=0x0E0F.
REQ-036 Decay clamp: gmax=0x1005, quiet input from gain 0x1000 -> gain=0x1005 after 1 update and stays at 0x1005; then gmax=0x0800 -> gain=0x0800 on the next update.
REQ-037 Freeze: freeze=1 with a continuous over-target input for 20 samples -> gain, state and hcnt unchanged; release -> attack on the next mv.
REQ-038 Reset mid-stream: iv on every cycle, rst_n pulsed low for 1 cycle while 3 samples are in flight -> ov=0 for those samples, gain=0x1000, the next iv gives ov 3 cycles later.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared widths, constants, FSM states and small arithmetic helpers for the AGC1 block.
// Gain is unsigned Q4.12; samples are 18-bit two's complement.
package agc_pkg;

  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 12;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h1000;

  localparam int SAMP_W = 18;
  localparam int PROD_W = 34;
  localparam int MAG_W  = 18;
  localparam int HANG_W = 12;

  localparam logic signed [SAMP_W-1:0] SAMP_MAX = 18'sh1FFFF;
  localparam logic signed [SAMP_W-1:0] SAMP_MIN = 18'sh20000;
  localparam logic        [MAG_W-1:0]  MAG_MAX  = 18'h3FFFF;

  typedef enum logic {
    ST_DECAY = 1'b0,
    ST_HANG  = 1'b1
  } agc_state_e;

  // Rescale a Q4.12-weighted product back to sample units and clamp to the 18-bit range.
  function automatic logic signed [SAMP_W-1:0] scale_sat(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] shifted;
    shifted = prod >>> GAIN_FRAC;
    if (shifted > 34'sd131071) begin
      return SAMP_MAX;
    end else if (shifted < -34'sd131072) begin
      return SAMP_MIN;
    end else begin
      return shifted[SAMP_W-1:0];
    end
  endfunction

  // |v| with the single unrepresentable case (-131072) folded onto 131071.
  function automatic logic [SAMP_W-2:0] abs_sat(input logic signed [SAMP_W-1:0] v);
    logic signed [SAMP_W-1:0] neg;
    neg = -v;
    if (v == SAMP_MIN) begin
      return '1;
    end else if (v[SAMP_W-1]) begin
      return neg[SAMP_W-2:0];
    end else begin
      return v[SAMP_W-2:0];
    end
  endfunction

endpackage

// File: rtl/agc1_if.sv
// I/Q sample stream of the AGC: blanked pair in with its valid, scaled pair out with its valid.
// The producer side holds the master modport, the AGC holds the slave modport.
interface agc1_if;

  logic signed [agc_pkg::SAMP_W-1:0] dix;
  logic signed [agc_pkg::SAMP_W-1:0] diy;
  logic                              iv;
  logic signed [agc_pkg::SAMP_W-1:0] dox;
  logic signed [agc_pkg::SAMP_W-1:0] doy;
  logic                              ov;

  modport master (
    output dix, diy, iv,
    input  dox, doy, ov
  );

  modport slave (
    input  dix, diy, iv,
    output dox, doy, ov
  );

endinterface

// File: rtl/agc1_cmag18.sv
// Registered alpha-max-beta-min magnitude of an 18-bit I/Q pair: max(|x|,|y|) + min(|x|,|y|)/2.
// One cycle of latency; the magnitude holds its last value between valid pairs.
module cmag18
  import agc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [SAMP_W-1:0] i_x,
  input  logic signed [SAMP_W-1:0] i_y,
  input  logic                     i_v,
  output logic        [MAG_W-1:0]  o_mag,
  output logic                     o_mv
);

  logic [SAMP_W-2:0] w_a;
  logic [SAMP_W-2:0] w_b;
  logic [SAMP_W-2:0] w_max;
  logic [SAMP_W-2:0] w_half_min;
  logic [MAG_W:0]    w_sum;
  logic [MAG_W-1:0]  w_mag;

  logic [MAG_W-1:0]  r_mag;
  logic              r_mv;

  assign w_a        = abs_sat(i_x);
  assign w_b        = abs_sat(i_y);
  assign w_max      = (w_a >= w_b) ? w_a : w_b;
  assign w_half_min = ((w_a >= w_b) ? w_b : w_a) >> 1;
  assign w_sum      = (MAG_W+1)'(w_max) + (MAG_W+1)'(w_half_min);
  assign w_mag      = w_sum[MAG_W] ? MAG_MAX : w_sum[MAG_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag <= '0;
      r_mv  <= 1'b0;
    end else begin
      r_mv <= i_v;
      if (i_v) begin
        r_mag <= w_mag;
      end
    end
  end

  assign o_mag = r_mag;
  assign o_mv  = r_mv;

endmodule

// File: rtl/agc1.sv
// AGC1: three-stage gain-scaling pipeline for an I/Q stream plus a fast-attack / hang / slow-decay
// gain loop driven by the registered magnitude of the scaled output.
module agc1
  import agc_pkg::*;
#(
  parameter int               ATTACK_SH = 3,
  parameter int               DECAY_SH  = 8,
  parameter logic [GAIN_W-1:0] GAIN_INIT = GAIN_UNITY
) (
  input  logic               clk,
  input  logic               rst_n,
  agc1_if.slave              bus,
  input  logic [HANG_W-1:0]  target,
  input  logic [HANG_W-1:0]  hang,
  input  logic [GAIN_W-1:0]  gmax,
  input  logic               freeze,
  output logic [GAIN_W-1:0]  gain
);

  // Sample pipeline: S1 input capture, S2 product, S3 saturated output.
  logic signed [SAMP_W-1:0] r_s1_x;
  logic signed [SAMP_W-1:0] r_s1_y;
  logic                     r_s1_v;
  logic signed [PROD_W-1:0] r_s2_x;
  logic signed [PROD_W-1:0] r_s2_y;
  logic                     r_s2_v;
  logic signed [SAMP_W-1:0] r_dox;
  logic signed [SAMP_W-1:0] r_doy;
  logic                     r_ov;

  logic signed [PROD_W-1:0] w_gain_ext;
  logic signed [PROD_W-1:0] w_px;
  logic signed [PROD_W-1:0] w_py;

  // Gain loop state.
  agc_state_e               r_state;
  agc_state_e               w_state_nxt;
  logic [HANG_W-1:0]        r_hcnt;
  logic [HANG_W-1:0]        w_hcnt_nxt;
  logic [GAIN_W-1:0]        r_gain;
  logic [GAIN_W-1:0]        w_gain_nxt;

  logic [MAG_W-1:0]         w_mag;
  logic                     w_mv;
  logic                     w_attack;
  logic [GAIN_W-1:0]        w_att_gain;
  logic [GAIN_W:0]          w_dec_sum;
  logic [GAIN_W-1:0]        w_dec_gain;

  // The gain is zero-extended so the multiply stays signed-by-unsigned; the true product fits 34 bits.
  assign w_gain_ext = $signed({{(PROD_W-GAIN_W){1'b0}}, r_gain});
  assign w_px       = PROD_W'(r_s1_x) * w_gain_ext;
  assign w_py       = PROD_W'(r_s1_y) * w_gain_ext;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the previous
  // stage's pre-edge value; blocking here would collapse the pipeline into a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_x <= '0;
      r_s1_y <= '0;
      r_s1_v <= 1'b0;
      r_s2_x <= '0;
      r_s2_y <= '0;
      r_s2_v <= 1'b0;
      r_dox  <= '0;
      r_doy  <= '0;
      r_ov   <= 1'b0;
    end else begin
      r_s1_v <= bus.iv;
      r_s2_v <= r_s1_v;
      r_ov   <= r_s2_v;
      if (bus.iv) begin
        r_s1_x <= bus.dix;
        r_s1_y <= bus.diy;
      end
      if (r_s1_v) begin
        r_s2_x <= w_px;
        r_s2_y <= w_py;
      end
      if (r_s2_v) begin
        r_dox <= scale_sat(r_s2_x);
        r_doy <= scale_sat(r_s2_y);
      end
    end
  end

  assign bus.dox = r_dox;
  assign bus.doy = r_doy;
  assign bus.ov  = r_ov;

  cmag18 u_cmag (
    .clk   (clk),
    .rst_n (rst_n),
    .i_x   (r_dox),
    .i_y   (r_doy),
    .i_v   (r_ov),
    .o_mag (w_mag),
    .o_mv  (w_mv)
  );

  // mag[17:6] > target is the same as mag > {target, 6'h3F}, which avoids dropping the low bits.
  assign w_attack   = (w_mag > {target, 6'h3F});
  assign w_att_gain = ((r_gain - (r_gain >> ATTACK_SH)) == '0) ? GAIN_W'(1)
                                                             : (r_gain - (r_gain >> ATTACK_SH));
  // Computed one bit wider so the decay step cannot wrap; this single compare also pulls a gain
  // that sits above a lowered gmax straight down to gmax.
  assign w_dec_sum  = {1'b0, r_gain} + (GAIN_W+1)'(r_gain >> DECAY_SH) + (GAIN_W+1)'(1);
  assign w_dec_gain = (w_dec_sum > {1'b0, gmax}) ? gmax : w_dec_sum[GAIN_W-1:0];

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned
  // and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_gain_nxt  = r_gain;
    if (w_mv && !freeze) begin
      if (w_attack) begin
        w_gain_nxt  = w_att_gain;
        w_hcnt_nxt  = hang;
        w_state_nxt = ST_HANG;
      end else begin
        unique case (r_state)
          ST_HANG: begin
            if (r_hcnt == '0) begin
              w_state_nxt = ST_DECAY;
            end else begin
              w_hcnt_nxt = r_hcnt - HANG_W'(1);
            end
          end
          ST_DECAY: begin
            w_gain_nxt = w_dec_gain;
          end
          default: begin
            w_state_nxt = ST_DECAY;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_DECAY;
      r_hcnt  <= '0;
      r_gain  <= GAIN_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_gain  <= w_gain_nxt;
    end
  end

  assign gain = r_gain;

endmodule

// File: tb/tb_agc1.sv
// Scoreboard bench for agc1: directed I/Q vectors with hand-computed outputs queued at issue time,
// an independent monitor comparing each ov pulse, and direct gain checks between transactions.
module tb_agc1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] target;
  logic [11:0] hang;
  logic [15:0] gmax;
  logic        freeze;
  logic [15:0] gain;

  agc1_if bus ();

  agc1 #(
    .ATTACK_SH (3),
    .DECAY_SH  (8),
    .GAIN_INIT (16'h1000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .target (target),
    .hang   (hang),
    .gmax   (gmax),
    .freeze (freeze),
    .gain   (gain)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every ov pulse must match the oldest queued expectation, exactly 3 cycles after issue.
  always @(negedge clk) begin
    if (bus.ov !== 1'b0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ov: got ov=%b with no sample pending, expected ov=0 at cycle %0d", bus.ov, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("dox", bus.dox, mon_e.x);
        check("doy", bus.doy, mon_e.y);
        check("ov_latency", cyc - mon_e.cyc, 3);
      end
    end
  end

  // Present one pair for one cycle (iv left high so consecutive calls stream back-to-back).
  task automatic drive(input int x, input int y, input int ex, input int ey);
    @(posedge clk);
    #1;
    bus.iv  = 1'b1;
    bus.dix = 18'(x);
    bus.diy = 18'(y);
    sb.push_back('{ex, ey, cyc});
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    bus.iv = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  // Isolated sample: long enough idle afterwards for ov, mv and the gain update to complete.
  task automatic send(input int x, input int y, input int ex, input int ey);
    drive(x, y, ex, ey);
    idle(8);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    bus.iv = 1'b0;
    sb.delete();
    #2;
    check("rst_ov", bus.ov, 0);
    check("rst_dox", bus.dox, 0);
    check("rst_doy", bus.doy, 0);
    check("rst_gain", gain, 16'h1000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.iv  = 1'b0;
    bus.dix = '0;
    bus.diy = '0;
    target  = 12'hFFF;
    hang    = 12'd4;
    gmax    = 16'h1000;
    freeze  = 1'b0;

    do_reset();

    // Unity pass-through, including full-scale values; decay is clamped at gmax=0x1000.
    send(1000, -2000, 1000, -2000);
    check("unity_gain", gain, 16'h1000);
    send(-1, 7, -1, 7);
    send(131071, -131072, 131071, -131072);
    check("unity_gain_fs", gain, 16'h1000);

    // mag[17:6] == target is not an attack.
    target = 12'h200;
    send(32768, 0, 32768, 0);
    check("equal_no_attack", gain, 16'h1000);

    // Attack, four hang samples, return to DECAY, then one decay step.
    target = 12'h100;
    send(32768, 0, 32768, 0);
    check("attack_gain", gain, 16'h0E00);
    send(0, 0, 0, 0);
    check("hang1", gain, 16'h0E00);
    send(4096, -4096, 3584, -3584);
    check("hang2", gain, 16'h0E00);
    send(0, 0, 0, 0);
    check("hang3", gain, 16'h0E00);
    send(0, 0, 0, 0);
    check("hang4", gain, 16'h0E00);
    send(0, 0, 0, 0);
    check("hang_to_decay", gain, 16'h0E00);
    send(0, 0, 0, 0);
    check("first_decay", gain, 16'h0E0F);

    // Decay clamp to gmax, then a runtime-lowered gmax.
    do_reset();
    target = 12'hFFF;
    gmax   = 16'h1005;
    send(0, 0, 0, 0);
    check("decay_clamp1", gain, 16'h1005);
    send(0, 0, 0, 0);
    check("decay_clamp2", gain, 16'h1005);
    gmax = 16'h0800;
    send(0, 0, 0, 0);
    check("gmax_lowered", gain, 16'h0800);

    // Back-to-back quiet stream decays the gain up to gmax=0x8000 (x8).
    gmax = 16'h8000;
    for (int i = 0; i < 1200; i++) drive(0, 0, 0, 0);
    idle(8);
    check("decay_to_gmax", gain, 16'h8000);

    // Saturation at gain x8, including the exact boundaries.
    send(20000, 0, 131071, 0);
    send(-20000, 0, -131072, 0);
    send(0, -20000, 0, -131072);
    send(16384, -16384, 131071, -131072);
    send(16383, -16383, 131064, -131064);
    send(100, -100, 800, -800);
    check("sat_gain_held", gain, 16'h8000);

    // Freeze holds gain through 20 over-target samples; release attacks on the next mv.
    target = 12'h100;
    hang   = 12'd0;
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) drive(20000, 20000, 131071, 131071);
    idle(8);
    check("freeze_gain", gain, 16'h8000);
    freeze = 1'b0;
    send(20000, 20000, 131071, 131071);
    check("release_attack", gain, 16'h7000);

    // hang=0: next quiet sample returns to DECAY without a gain change, the one after decays.
    send(0, 0, 0, 0);
    check("hang0_return", gain, 16'h7000);
    send(0, 0, 0, 0);
    check("hang0_decay", gain, 16'h7071);

    // Reset mid-stream: in-flight samples must not emerge; first sample after reset has latency 3.
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);
    do_reset();
    send(1000, -2000, 1000, -2000);
    check("post_reset_decay", gain, 16'h1011);

    idle(10);
    check("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
